// File: rtl/pd_loop_ctrl.sv
// Sequencer for one PD control iteration: ADC sample, wait for the PD pipeline, clamp and write the DAC.
// Optional anti-windup clamp on the stored integral is enabled by defining PD_LOOP_ANTIWINDUP_EN.
module pd_loop_ctrl #(
  parameter int INPUT_WIDTH    = 18,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int DAC_WIDTH      = 20,
  parameter int PIPE_LATENCY   = 4,
  parameter int INTEGRAL_LIMIT = 2**24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_enable,
  input  logic                           i_clear_integral,
  output logic                           o_adc_arm,
  input  logic                           i_adc_finished,
  input  logic signed [INPUT_WIDTH-1:0]  i_adc_data,
  output logic signed [INPUT_WIDTH-1:0]  o_actual,
  output logic signed [OUTPUT_WIDTH-1:0] o_integral,
  input  logic signed [OUTPUT_WIDTH-1:0] i_integral_next,
  input  logic signed [OUTPUT_WIDTH-1:0] i_pd,
  output logic                           o_dac_arm,
  output logic signed [DAC_WIDTH-1:0]    o_dac_data,
  input  logic                           i_dac_finished,
  output logic                           o_running,
  output logic [31:0]                    o_sample_count
);

  localparam int CNT_W = $clog2(PIPE_LATENCY + 1);
  localparam logic signed [OUTPUT_WIDTH-1:0] DAC_MAX = OUTPUT_WIDTH'(2**(DAC_WIDTH-1) - 1);
  localparam logic signed [OUTPUT_WIDTH-1:0] DAC_MIN = ~DAC_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_ADC_REQ, S_ADC_WAIT, S_PIPE_WAIT, S_DAC_REQ, S_DAC_WAIT
  } state_t;

  state_t                         r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_adc_arm;
  logic                           r_dac_arm;
  logic signed [INPUT_WIDTH-1:0]  r_actual;
  logic signed [OUTPUT_WIDTH-1:0] r_integral;
  logic signed [DAC_WIDTH-1:0]    r_dac_data;
  logic [31:0]                    r_sample_count;

  logic signed [DAC_WIDTH-1:0]    w_dac_sat;
  logic signed [OUTPUT_WIDTH-1:0] w_int_cap;

  always_comb begin
    w_dac_sat = i_pd[DAC_WIDTH-1:0];
    if (i_pd > DAC_MAX)
      w_dac_sat = DAC_MAX[DAC_WIDTH-1:0];
    else if (i_pd < DAC_MIN)
      w_dac_sat = DAC_MIN[DAC_WIDTH-1:0];
  end

`ifdef PD_LOOP_ANTIWINDUP_EN
  localparam logic signed [OUTPUT_WIDTH-1:0] INT_MAX = OUTPUT_WIDTH'(INTEGRAL_LIMIT);
  localparam logic signed [OUTPUT_WIDTH-1:0] INT_MIN = -INT_MAX;

  always_comb begin
    w_int_cap = i_integral_next;
    if (i_integral_next > INT_MAX)
      w_int_cap = INT_MAX;
    else if (i_integral_next < INT_MIN)
      w_int_cap = INT_MIN;
  end
`else
  logic w_unused_limit;
  assign w_unused_limit = (INTEGRAL_LIMIT != 0);
  assign w_int_cap      = i_integral_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_adc_arm      <= 1'b0;
      r_dac_arm      <= 1'b0;
      r_actual       <= '0;
      r_integral     <= '0;
      r_dac_data     <= '0;
      r_sample_count <= '0;
    end else begin
      r_adc_arm <= 1'b0;
      r_dac_arm <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_clear_integral)
            r_integral <= '0;
          if (i_enable) begin
            r_state   <= S_ADC_REQ;
            r_adc_arm <= 1'b1;
          end
        end
        S_ADC_REQ: r_state <= S_ADC_WAIT;
        S_ADC_WAIT: begin
          if (i_adc_finished) begin
            r_actual <= i_adc_data;
            r_cnt    <= CNT_W'(PIPE_LATENCY);
            r_state  <= S_PIPE_WAIT;
          end
        end
        // Pipeline inputs stay frozen here; i_pd is valid once the counter has run down to 1.
        S_PIPE_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_dac_data <= w_dac_sat;
            r_integral <= w_int_cap;
            r_state    <= S_DAC_REQ;
            r_dac_arm  <= 1'b1;
          end
        end
        S_DAC_REQ: r_state <= S_DAC_WAIT;
        S_DAC_WAIT: begin
          if (i_dac_finished) begin
            r_sample_count <= r_sample_count + 32'd1;
            if (i_enable) begin
              r_state   <= S_ADC_REQ;
              r_adc_arm <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_adc_arm      = r_adc_arm;
  assign o_dac_arm      = r_dac_arm;
  assign o_actual       = r_actual;
  assign o_integral     = r_integral;
  assign o_dac_data     = r_dac_data;
  assign o_sample_count = r_sample_count;
  assign o_running      = (r_state != S_IDLE);

endmodule

// File: tb/tb_pd_loop_ctrl.sv
// Bench for pd_loop_ctrl: behavioural PD pipeline stand-in plus a transaction-level model of
// DAC code, stored integral, iteration count and handshake timing.
module tb_pd_loop_ctrl;

  localparam int  LAT    = 4;
  localparam longint DAC_HI = 524287;
  localparam longint DAC_LO = -524288;
  localparam longint ILIM   = 2**24;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_enable, i_clear_integral;
  logic               o_adc_arm, i_adc_finished;
  logic signed [17:0] i_adc_data, o_actual;
  logic signed [31:0] o_integral, i_integral_next, i_pd;
  logic               o_dac_arm, i_dac_finished, o_running;
  logic signed [19:0] o_dac_data;
  logic [31:0]        o_sample_count;

  logic signed [31:0] pd_gain, pd_off, int_off;
  longint             exp_int, exp_count;
  int                 n_cmp = 0, n_err = 0;

  pd_loop_ctrl #(.INPUT_WIDTH(18), .OUTPUT_WIDTH(32), .DAC_WIDTH(20),
                 .PIPE_LATENCY(LAT), .INTEGRAL_LIMIT(2**24)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_clear_integral(i_clear_integral),
    .o_adc_arm(o_adc_arm), .i_adc_finished(i_adc_finished), .i_adc_data(i_adc_data),
    .o_actual(o_actual), .o_integral(o_integral), .i_integral_next(i_integral_next),
    .i_pd(i_pd), .o_dac_arm(o_dac_arm), .o_dac_data(o_dac_data),
    .i_dac_finished(i_dac_finished), .o_running(o_running), .o_sample_count(o_sample_count)
  );

  // Pipeline stand-in: pd = gain*actual + off, integral_next = integral + actual + off.
  assign i_pd            = pd_gain * {{14{o_actual[17]}}, o_actual} + pd_off;
  assign i_integral_next = o_integral + {{14{o_actual[17]}}, o_actual} + int_off;

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic longint sat_dac(input longint v);
    return (v > DAC_HI) ? DAC_HI : (v < DAC_LO) ? DAC_LO : v;
  endfunction

  function automatic longint store_int(input longint v);
`ifdef PD_LOOP_ANTIWINDUP_EN
    return (v > ILIM) ? ILIM : (v < -ILIM) ? -ILIM : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full loop iteration; called at a negedge, returns at the negedge after the DAC handshake.
  task automatic run_iter(input logic signed [17:0] val, input int adc_dly, input int dac_dly,
                          input logic en_after, input logic clr_dac);
    int     k;
    logic   seen;
    longint exp_dac;
    if (!o_running) i_enable = 1'b1;
    k = 0;
    while (!o_adc_arm && k < 20) begin @(negedge clk); k++; end
    check("adc_arm_seen", o_adc_arm, 1);
    @(negedge clk);
    check("adc_arm_pulse", o_adc_arm, 0);
    repeat (adc_dly - 1) begin i_adc_data = 18'($urandom()); @(negedge clk); end
    i_adc_finished = 1'b1;
    i_adc_data     = val;
    @(negedge clk);
    i_adc_finished = 1'b0;
    i_adc_data     = 18'($urandom());
    i_enable       = en_after;
    check("actual_latched", o_actual, val);
    exp_dac = sat_dac(longint'(pd_gain) * longint'(val) + longint'(pd_off));
    exp_int = store_int(exp_int + longint'(val) + longint'(int_off));
    k = 1;
    while (!o_dac_arm && k < 20) begin @(negedge clk); k++; end
    check("dac_arm_latency", k, LAT + 1);
    check("actual_held", o_actual, val);
    check("dac_data", o_dac_data, exp_dac);
    check("integral", o_integral, exp_int);
    i_clear_integral = clr_dac;
    @(negedge clk);
    check("dac_arm_pulse", o_dac_arm, 0);
    repeat (dac_dly - 1) @(negedge clk);
    i_dac_finished   = 1'b1;
    i_clear_integral = 1'b0;
    @(negedge clk);
    i_dac_finished = 1'b0;
    exp_count++;
    check("sample_count", o_sample_count, exp_count);
    check("integral_after", o_integral, exp_int);
    check("running_after", o_running, en_after);
    if (!en_after) begin
      seen = 1'b0;
      repeat (8) begin @(negedge clk); if (o_adc_arm || o_running) seen = 1'b1; end
      check("idle_no_arm", seen, 0);
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1; i_enable = 0; i_clear_integral = 0; i_adc_finished = 0; i_adc_data = '0;
    i_dac_finished = 0; pd_gain = 0; pd_off = 0; int_off = 0; exp_int = 0; exp_count = 0;
    repeat (2) @(negedge clk);
    check("rst_adc_arm", o_adc_arm, 0);
    check("rst_dac_arm", o_dac_arm, 0);
    check("rst_actual", o_actual, 0);
    check("rst_integral", o_integral, 0);
    check("rst_dac_data", o_dac_data, 0);
    check("rst_count", o_sample_count, 0);
    check("rst_running", o_running, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_disabled", o_running, 0);

    // Nominal: ADC returns 100 one cycle after arm, pd = 5*actual.
    pd_gain = 5;
    run_iter(18'sd100, 1, 1, 1'b1, 1'b0);

    // Randomised iterations with varied handshake delays, gains and offsets.
    for (int i = 0; i < 14; i++) begin
      pd_gain = 32'($urandom_range(0, 32)) - 32'sd16;
      pd_off  = 32'($urandom_range(0, 2000)) - 32'sd1000;
      int_off = 32'($urandom_range(0, 2000)) - 32'sd1000;
      run_iter(18'($urandom()), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
               1'($urandom()), 1'b0);
    end

    // DAC saturation at both rails.
    pd_gain = 0; int_off = 0;
    pd_off = 2**24;
    run_iter(18'sd7, 1, 1, 1'b1, 1'b0);
    pd_off = -(2**24);
    run_iter(-18'sd7, 2, 2, 1'b1, 1'b0);

    // Integral pushed to 2**25.
    pd_off  = 0;
    int_off = 32'(longint'(2**25) - exp_int - 64'sd9);
    run_iter(18'sd9, 1, 1, 1'b1, 1'b0);
    int_off = 0;

    // Enable dropped during PIPE_WAIT: iteration completes, then idle.
    run_iter(18'sd42, 1, 3, 1'b0, 1'b0);

    // Clear honoured in IDLE, ignored in DAC_WAIT.
    int_off = 32'(64'sd1234 - exp_int - 64'sd55);
    run_iter(18'sd55, 1, 1, 1'b0, 1'b0);
    check("int_1234", o_integral, 1234);
    int_off = 0;
    i_clear_integral = 1'b1;
    @(negedge clk);
    i_clear_integral = 1'b0;
    exp_int = 0;
    check("clear_idle", o_integral, 0);
    run_iter(18'sd321, 2, 3, 1'b0, 1'b1);

    // Reset pulsed in ADC_WAIT; a late ADC strobe must not restart anything.
    i_enable = 1'b1;
    for (int k = 0; k < 20 && !o_adc_arm; k++) @(negedge clk);
    i_enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_int = 0; exp_count = 0;
    check("mrst_adc_arm", o_adc_arm, 0);
    check("mrst_dac_arm", o_dac_arm, 0);
    check("mrst_actual", o_actual, 0);
    check("mrst_integral", o_integral, 0);
    check("mrst_dac_data", o_dac_data, 0);
    check("mrst_count", o_sample_count, 0);
    check("mrst_running", o_running, 0);
    @(negedge clk);
    rst = 1'b0;
    i_adc_finished = 1'b1;
    i_adc_data     = 18'sd777;
    @(negedge clk);
    i_adc_finished = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (o_dac_arm || o_adc_arm || o_running) seen = 1'b1; end
    check("late_adc_ignored", seen, 0);
    check("late_actual", o_actual, 0);

    // Loop resumes normally from IDLE after reset.
    pd_gain = 3;
    run_iter(-18'sd2000, 1, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pd_loop_ctrl.md
PD_LOOP_CTRL -- requirements
Module: pd_loop_ctrl

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 18, meaning ADC sample width and pd_pipeline input width.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 32, meaning pd_pipeline output and integral width.
REQ-003 SHALL have parameter DAC_WIDTH, default 20, meaning signed DAC code width.
REQ-004 SHALL have parameter PIPE_LATENCY, default 4, meaning cycles from stable pipeline inputs to valid i_pd.
REQ-005 SHALL have parameter INTEGRAL_LIMIT, default 2**24, meaning positive integral clamp magnitude.
REQ-006 SHALL have port clk, input, 1, the only clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port i_enable, input, 1, run the loop while high.
REQ-009 SHALL have port i_clear_integral, input, 1, zero the integral; honoured only in IDLE.
REQ-010 SHALL have port o_adc_arm, output, 1, one-cycle ADC conversion request.
REQ-011 SHALL have port i_adc_finished, input, 1, ADC sample valid strobe.
REQ-012 SHALL have port i_adc_data, input, INPUT_WIDTH signed, ADC sample.
REQ-013 SHALL have port o_actual, output, INPUT_WIDTH signed, registered sample to pipeline i_actual.
REQ-014 SHALL have port o_integral, output, OUTPUT_WIDTH signed, stored integral to pipeline i_integral.
REQ-015 SHALL have port i_integral_next, input, OUTPUT_WIDTH signed, from pipeline o_integral.
REQ-016 SHALL have port i_pd, input, OUTPUT_WIDTH signed, from pipeline o_pd.
REQ-017 SHALL have port o_dac_arm, output, 1, one-cycle DAC write request.
REQ-018 SHALL have port o_dac_data, output, DAC_WIDTH signed, DAC code.
REQ-019 SHALL have port i_dac_finished, input, 1, DAC write complete strobe.
REQ-020 SHALL have port o_running, output, 1, high in any state other than IDLE.
REQ-021 SHALL have port o_sample_count, output, 32, completed loop iterations, wraps 2**32-1 to 0.

Function
REQ-022 SHALL implement states IDLE, ADC_REQ, ADC_WAIT, PIPE_WAIT, DAC_REQ, DAC_WAIT.
REQ-023 SHALL transition IDLE -> ADC_REQ on i_enable=1; otherwise remain in IDLE.
REQ-024 SHALL assert o_adc_arm for exactly the single ADC_REQ cycle, then go to ADC_WAIT.
REQ-025 SHALL, in ADC_WAIT on i_adc_finished=1, latch i_adc_data into o_actual, load the wait counter with PIPE_LATENCY, and go to PIPE_WAIT; i_adc_finished is ignored in all other states.
REQ-026 SHALL hold o_actual and o_integral constant throughout PIPE_WAIT.
REQ-027 SHALL decrement the counter each PIPE_WAIT cycle and, in the cycle it reads 1, capture i_pd into o_dac_data (REQ-031) and i_integral_next into o_integral (REQ-036/037), then go to DAC_REQ.
REQ-028 SHALL assert o_dac_arm for exactly the single DAC_REQ cycle, then go to DAC_WAIT.
REQ-029 SHALL, in DAC_WAIT on i_dac_finished=1, increment o_sample_count and go to ADC_REQ if i_enable=1, else IDLE.
REQ-030 SHALL ignore i_enable deassertion mid-iteration; the current iteration always completes through DAC_WAIT.
REQ-031 SHALL saturate i_pd to [-(2**(DAC_WIDTH-1)), 2**(DAC_WIDTH-1)-1] when forming o_dac_data; no wrap-around.
REQ-032 SHALL zero o_integral in IDLE when i_clear_integral=1; i_clear_integral is ignored elsewhere.
REQ-033 SHALL give minimum iteration length 1 + 1 + PIPE_LATENCY + 1 + 1 cycles with zero-wait handshakes (ADC_REQ, ADC_WAIT, PIPE_WAIT, DAC_REQ, DAC_WAIT).

Reset
REQ-034 SHALL, while rst=1, asynchronously force state IDLE, counter 0, and o_adc_arm, o_dac_arm, o_actual, o_integral, o_dac_data, o_sample_count all to 0.
REQ-035 SHALL resume from IDLE on the first clk edge after rst falls; a reset mid-iteration produces no DAC write.

Configuration
REQ-036 SHALL, when PD_LOOP_ANTIWINDUP_EN is defined, clamp the captured i_integral_next to [-INTEGRAL_LIMIT, INTEGRAL_LIMIT] before storing it in o_integral.
REQ-037 SHALL, when PD_LOOP_ANTIWINDUP_EN is undefined, store i_integral_next unmodified; the parameter INTEGRAL_LIMIT is then unused.

Verification
REQ-038 SHALL cover nominal: i_enable=1, ADC returns 100 one cycle after arm, i_pd model = 5*actual -> o_dac_data=500, o_dac_arm exactly PIPE_LATENCY+1 cycles after i_adc_finished, o_sample_count=1.
REQ-039 SHALL cover saturation: i_pd=2**24 -> o_dac_data=524287; i_pd=-(2**24) -> o_dac_data=-524288.
REQ-040 SHALL cover anti-windup: i_integral_next=2**25 -> o_integral=2**24 with PD_LOOP_ANTIWINDUP_EN defined; 2**25 without it.
REQ-041 SHALL cover enable drop: i_enable falls during PIPE_WAIT -> DAC write still occurs, then IDLE, o_running=0, no further o_adc_arm.
REQ-042 SHALL cover reset mid-op: rst pulsed during ADC_WAIT -> all outputs 0 immediately; a late i_adc_finished is ignored.
REQ-043 SHALL cover clear: o_integral=1234 in IDLE, i_clear_integral=1 -> o_integral=0 next cycle; in DAC_WAIT -> unchanged.
